// File: rtl/hilo_md_unit_pkg.sv
`default_nettype none
//============================================================================
// hilo_pkg: op_code values and FSM state encoding for the HI/LO unit.
// Rev 1.0
//============================================================================
package hilo_pkg;

   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam logic [2:0] OP_RSVD  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } state_t;

   // NOP and the reserved code never count as an accepted operation.
   function automatic logic op_is_real(input logic [2:0] op);
      return (op != OP_NOP) && (op != OP_RSVD);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_md_unit_if.sv
`default_nettype none
//============================================================================
// hilo_md_unit_if: execute-stage handshake and MFHI/MFLO read bus.
// Rev 1.0
//============================================================================
interface hilo_md_unit_if #(
   parameter int W = 32
);
   logic         op_valid;
   logic [2:0]   op_code;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         op_ready;
   logic         flush;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic         hi_r;
   logic         lo_r;
   logic [W-1:0] rdata;

   modport master (
      output op_valid, op_code, op_a, op_b, flush, hi_r, lo_r,
      input  op_ready, busy, done, div_by_zero, rdata
   );

   modport slave (
      input  op_valid, op_code, op_a, op_b, flush, hi_r, lo_r,
      output op_ready, busy, done, div_by_zero, rdata
   );
endinterface
`default_nettype wire

// File: rtl/hilo_md_unit_iter_md_core.sv
`default_nettype none
//============================================================================
// iter_md_core: radix-2 shift-add multiply / restoring divide over magnitudes.
// Rev 1.0
//============================================================================
module iter_md_core #(
   parameter int W = 32
) (
   input  wire logic           clk,
   input  wire logic           resetn,
   input  wire logic           start,
   input  wire logic           abort,
   input  wire logic           is_div,
   input  wire logic [W-1:0]   mag_a,
   input  wire logic [W-1:0]   mag_b,
   output logic      [2*W-1:0] result,
   output logic                last
);
   localparam int CW = $clog2(W + 1);

   logic [2*W-1:0] acc;
   logic [W-1:0]   opnd;
   logic           div_mode;
   logic [CW-1:0]  cnt;
   logic [W:0]     mul_sum;
   logic [W:0]     rem_shift;
   logic [W:0]     diff;

   // acc holds {partial, multiplier} for multiply, {remainder, dividend/quotient} for divide.
   always_comb begin
      mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
      rem_shift = acc[2*W-1:W-1];
      diff      = rem_shift - {1'b0, opnd};
      result    = {mul_sum, acc[W-1:1]};
      if (div_mode) begin
         if (!diff[W]) result = {diff[W-1:0], acc[W-2:0], 1'b1};
         else          result = {rem_shift[W-1:0], acc[W-2:0], 1'b0};
      end
   end

   assign last = (cnt == CW'(1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc      <= '0;
         opnd     <= '0;
         div_mode <= 1'b0;
         cnt      <= '0;
      end else if (abort) begin
         cnt <= '0;
      end else if (start) begin
         cnt      <= CW'(W);
         div_mode <= is_div;
         opnd     <= is_div ? mag_b : mag_a;
         acc      <= {{W{1'b0}}, (is_div ? mag_a : mag_b)};
      end else if (cnt != '0) begin
         acc <= result;
         cnt <= cnt - CW'(1);
      end
   end
endmodule
`default_nettype wire

// File: rtl/hilo_md_unit.sv
`default_nettype none
//============================================================================
// hilo_md_unit: HI/LO register file with iterative MULT/DIV, MTHI/MTLO, MFHI/MFLO.
// Rev 1.0
//============================================================================
module hilo_md_unit
   import hilo_pkg::*;
#(
   parameter int W      = 32,
   parameter bit BYPASS = 1'b0
) (
   input  wire logic     clk,
   input  wire logic     resetn,
   hilo_md_unit_if.slave bus
);
   state_t         state;
   state_t         state_nxt;
   logic [W-1:0]   hi;
   logic [W-1:0]   lo;
   logic           done_q;
   logic           dbz_q;
   logic           neg_x;
   logic           neg_a;
   logic           zero_div;
   logic [W-1:0]   a_raw;

   logic           accept;
   logic           is_md;
   logic           is_div_op;
   logic           is_signed;
   logic           sign_a;
   logic           sign_b;
   logic [W-1:0]   mag_a;
   logic [W-1:0]   mag_b;
   logic           start;
   logic           abort;
   logic           commit;
   logic           last;
   logic [2*W-1:0] res;
   logic [2*W-1:0] prod;
   logic [W-1:0]   quo;
   logic [W-1:0]   rem;
   logic [W-1:0]   hi_n;
   logic [W-1:0]   lo_n;
   logic [W-1:0]   hi_view;
   logic [W-1:0]   lo_view;

   always_comb begin
      is_md     = (bus.op_code == OP_MULT) || (bus.op_code == OP_MULTU) ||
                  (bus.op_code == OP_DIV)  || (bus.op_code == OP_DIVU);
      is_div_op = (bus.op_code == OP_DIV)  || (bus.op_code == OP_DIVU);
      is_signed = (bus.op_code == OP_MULT) || (bus.op_code == OP_DIV);
      accept    = bus.op_valid && (state == ST_IDLE) && !bus.flush && op_is_real(bus.op_code);
      sign_a    = is_signed && bus.op_a[W-1];
      sign_b    = is_signed && bus.op_b[W-1];
      mag_a     = sign_a ? -bus.op_a : bus.op_a;
      mag_b     = sign_b ? -bus.op_b : bus.op_b;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      abort     = 1'b0;
      commit    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept && is_md) begin
               state_nxt = is_div_op ? ST_DIV : ST_MUL;
               start     = 1'b1;
            end
         end
         ST_MUL, ST_DIV: begin
            if (bus.flush) begin
               state_nxt = ST_IDLE;
               abort     = 1'b1;
            end else if (last) begin
               state_nxt = ST_IDLE;
               commit    = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   iter_md_core #(.W(W)) u_core (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .abort  (abort),
      .is_div (is_div_op),
      .mag_a  (mag_a),
      .mag_b  (mag_b),
      .result (res),
      .last   (last)
   );

   // Sign fix-up: product negates as a 2W-bit value; quotient and remainder separately.
   always_comb begin
      prod = neg_x ? -res : res;
      quo  = neg_x ? -res[W-1:0] : res[W-1:0];
      rem  = neg_a ? -res[2*W-1:W] : res[2*W-1:W];
      hi_n = prod[2*W-1:W];
      lo_n = prod[W-1:0];
      if (state == ST_DIV) begin
         if (zero_div) begin
            hi_n = a_raw;
            lo_n = '1;
         end else begin
            hi_n = rem;
            lo_n = quo;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi       <= '0;
         lo       <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         neg_x    <= 1'b0;
         neg_a    <= 1'b0;
         zero_div <= 1'b0;
         a_raw    <= '0;
      end else begin
         done_q <= commit;
         if (commit) begin
            hi <= hi_n;
            lo <= lo_n;
         end else if (accept && (bus.op_code == OP_MTHI)) begin
            hi <= bus.op_a;
         end else if (accept && (bus.op_code == OP_MTLO)) begin
            lo <= bus.op_a;
         end
         if (accept)                          dbz_q <= 1'b0;
         else if (commit && state == ST_DIV)  dbz_q <= zero_div;
         if (accept && is_md) begin
            neg_x    <= sign_a ^ sign_b;
            neg_a    <= sign_a;
            zero_div <= (bus.op_b == '0);
            a_raw    <= bus.op_a;
         end
      end
   end

   generate
      if (BYPASS) begin : g_bypass
         assign hi_view = (accept && bus.op_code == OP_MTHI) ? bus.op_a : hi;
         assign lo_view = (accept && bus.op_code == OP_MTLO) ? bus.op_a : lo;
      end else begin : g_no_bypass
         assign hi_view = hi;
         assign lo_view = lo;
      end
   endgenerate

   assign bus.rdata       = bus.lo_r ? lo_view : (bus.hi_r ? hi_view : '0);
   assign bus.op_ready    = (state == ST_IDLE);
   assign bus.busy        = (state == ST_MUL) || (state == ST_DIV);
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
endmodule
`default_nettype wire

// File: tb/tb_hilo_md_unit.sv
`default_nettype none
//============================================================================
// tb_hilo_md_unit: scoreboard bench with a plain-arithmetic HI/LO reference model.
// Rev 1.0
//============================================================================
module tb_hilo_md_unit;
   import hilo_pkg::*;

   typedef struct {
      bit          from_done;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } item_t;

   logic clk;
   logic resetn;
   logic chk_req;
   int   n_chk;
   int   n_fail;
   int   busy_run;
   item_t sbq[$];

   logic [31:0] m_hi;
   logic [31:0] m_lo;
   logic        m_dbz;

   hilo_md_unit_if #(.W(32)) bus ();

   hilo_md_unit #(.W(32), .BYPASS(1'b1)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model straight from the arithmetic definitions.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output logic d);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      d  = 1'b0;
      h  = m_hi;
      l  = m_lo;
      case (op)
         OP_MULT:  begin up = longint'(sa * sb); h = up[63:32]; l = up[31:0]; end
         OP_MULTU: begin up = ua * ub;           h = up[63:32]; l = up[31:0]; end
         OP_DIV, OP_DIVU: begin
            if (b == 32'd0) begin
               l = 32'hFFFF_FFFF; h = a; d = 1'b1;
            end else if (op == OP_DIV) begin
               sq = sa / sb; sr = sa % sb;
               l = sq[31:0]; h = sr[31:0];
            end else begin
               up = ua / ub; l = up[31:0];
               up = ua % ub; h = up[31:0];
            end
         end
         default: ;
      endcase
   endtask

   // Monitor: pops one expectation per done pulse or explicit check request.
   initial begin
      item_t it;
      bus.hi_r = 1'b0;
      bus.lo_r = 1'b0;
      busy_run = 0;
      forever begin
         @(negedge clk);
         if (bus.done || chk_req) begin
            if (sbq.size() == 0) begin
               cmp("unexpected_done", {63'd0, bus.done}, 64'd0);
            end else begin
               it = sbq.pop_front();
               cmp("event_kind", {63'd0, bus.done}, {63'd0, it.from_done});
               cmp("op_ready", {63'd0, bus.op_ready}, 64'd1);
               cmp("busy_idle", {63'd0, bus.busy}, 64'd0);
               cmp("div_by_zero", {63'd0, bus.div_by_zero}, {63'd0, it.dbz});
               if (it.from_done) cmp("busy_cycles", 64'(busy_run), 64'd32);
               bus.lo_r = 1'b1; bus.hi_r = 1'b0; #1;
               cmp("rdata_lo", {32'd0, bus.rdata}, {32'd0, it.lo});
               bus.lo_r = 1'b0; bus.hi_r = 1'b1; #1;
               cmp("rdata_hi", {32'd0, bus.rdata}, {32'd0, it.hi});
               bus.lo_r = 1'b1; #1;
               cmp("rdata_lo_prio", {32'd0, bus.rdata}, {32'd0, it.lo});
               bus.lo_r = 1'b0; bus.hi_r = 1'b0; #1;
               cmp("rdata_none", {32'd0, bus.rdata}, 64'd0);
            end
         end
         if (bus.busy) busy_run++;
         else          busy_run = 0;
      end
   end

   task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.op_valid = 1'b1; bus.op_code = op; bus.op_a = a; bus.op_b = b;
      @(posedge clk); #1;
      bus.op_valid = 1'b0; bus.op_code = OP_NOP;
   endtask

   task automatic chk();
      sbq.push_back('{1'b0, m_hi, m_lo, m_dbz});
      chk_req = 1'b1;
      @(posedge clk); #1;
      chk_req = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!(bus.op_ready && sbq.size() == 0)) begin
         @(posedge clk); #1;
         n++;
         if (n > 100) begin
            cmp("wait_idle_timeout", 64'd1, 64'd0);
            sbq.delete();
            break;
         end
      end
   endtask

   task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] h, l;
      logic        d;
      wait_idle();
      model(op, a, b, h, l, d);
      sbq.push_back('{1'b1, h, l, d});
      m_hi = h; m_lo = l; m_dbz = d;
      present(op, a, b);
      wait_idle();
   endtask

   task automatic run_mt(input logic [2:0] op, input logic [31:0] a, input bit bypass_chk);
      wait_idle();
      bus.op_valid = 1'b1; bus.op_code = op; bus.op_a = a; bus.op_b = 32'd0;
      if (bypass_chk) begin
         sbq.push_back('{1'b0, (op == OP_MTHI) ? a : m_hi, (op == OP_MTLO) ? a : m_lo, m_dbz});
         chk_req = 1'b1;
      end
      @(posedge clk); #1;
      chk_req = 1'b0;
      bus.op_valid = 1'b0; bus.op_code = OP_NOP;
      if (op == OP_MTHI) m_hi = a;
      else               m_lo = a;
      m_dbz = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      n_chk = 0; n_fail = 0;
      chk_req = 1'b0;
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;
      bus.op_valid = 1'b0; bus.op_code = OP_NOP; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #3 resetn = 1'b1;
      @(posedge clk); #1;
      chk();

      run_mt(OP_MTLO, 32'h0000_1234, 1'b1);
      run_mt(OP_MTHI, 32'hDEAD_BEEF, 1'b1);
      chk();

      run_md(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
      run_md(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005);
      run_md(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
      run_md(OP_DIVU,  32'd100,       32'd0);

      // Flush with a valid op in IDLE: nothing accepted, div_by_zero kept.
      bus.flush = 1'b1;
      present(OP_MULT, 32'd2, 32'd3);
      bus.flush = 1'b0;
      chk();

      run_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      run_md(OP_DIV, 32'h8000_0000, 32'd0);

      // Flush mid-multiply: registers keep their values, no done.
      wait_idle();
      m_dbz = 1'b0;
      present(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (9) @(posedge clk);
      #1 bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      chk();

      // Asynchronous reset mid-divide.
      wait_idle();
      present(OP_DIV, 32'h0000_0055, 32'd3);
      repeat (5) @(posedge clk);
      #2 resetn = 1'b0;
      #1 resetn = 1'b1;
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;
      chk();
      run_md(OP_DIVU, 32'd9, 32'd4);

      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 9))
            8:       op = OP_MTHI;
            9:       op = OP_MTLO;
            default: op = 3'($urandom_range(1, 4));
         endcase
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: b = 32'h8000_0000;
            3: a = 32'h8000_0000;
            4: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         if (op == OP_MTHI || op == OP_MTLO) begin
            run_mt(op, a, 1'b0);
            chk();
         end else begin
            run_md(op, a, b);
         end
      end
      wait_idle();
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
